// File: rtl/mux_tree_cfg_chain_if.sv
// Configuration-chain and routing-data bundle for one routing multiplexer.
// The master drives the chain controls and data inputs; the slave is the mux.
interface mux_tree_cfg_chain_if #(
  parameter int unsigned N_IN  = 15,
  parameter int unsigned CFG_W = 5
);
  logic              cfg_en;
  logic              ccff_head;
  logic              ccff_tail;
  logic              cfg_commit;
  logic              cfg_valid;
  logic [0:N_IN-1]   in;
  logic [CFG_W-1:0]  sram_q;
  logic              out;

  modport master (
    output cfg_en, ccff_head, cfg_commit, in,
    input  ccff_tail, cfg_valid, sram_q, out
  );

  modport slave (
    input  cfg_en, ccff_head, cfg_commit, in,
    output ccff_tail, cfg_valid, sram_q, out
  );
endinterface

// File: rtl/mux_tree_cfg_chain.sv
// Routing mux with a local config shift chain, a shadow (active) register
// loaded on commit, a binary select tree and an optional retiming flop.
module mux_tree_cfg_chain #(
  parameter int unsigned N_IN       = 15,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned REG_OUT_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mux_tree_cfg_chain_if.slave     bus
);
  localparam int unsigned CFG_W  = SEL_W + REG_OUT_EN;
  localparam int unsigned LEAVES = 1 << SEL_W;

  logic [CFG_W-1:0]  sr_q, sr_d;
  logic [CFG_W-1:0]  act_q, act_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  idx_c;
  logic [LEAVES-1:0] leaf_c;
  logic              mux_c;

  // Chain shifts toward the tail; commit always samples the pre-shift chain.
  always_comb begin
    sr_d    = sr_q;
    act_d   = act_q;
    valid_d = valid_q;
    if (bus.cfg_en) begin
      sr_d = CFG_W'({sr_q, bus.ccff_head});
    end
    if (bus.cfg_commit) begin
      act_d   = sr_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q    <= '0;
      act_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      act_q   <= act_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ccff_tail = sr_q[CFG_W-1];
  assign bus.cfg_valid = valid_q;
  assign bus.sram_q    = act_q;

  // Stored bits are inverted selects: all-ones config picks in[0].
  assign idx_c = ~act_q[SEL_W-1:0];

  for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
    if (g < N_IN) begin : g_used
      assign leaf_c[g] = bus.in[g];
    end else begin : g_tie
      assign leaf_c[g] = 1'b1;
    end
  end

  // Bottom-up reduction: level l pairs nodes using select bit l.
  always_comb begin
    logic [LEAVES-1:0] lvl;
    lvl = leaf_c;
    for (int l = 0; l < int'(SEL_W); l++) begin
      for (int j = 0; j < int'(LEAVES >> (l + 1)); j++) begin
        lvl[j] = idx_c[l] ? lvl[2*j+1] : lvl[2*j];
      end
    end
    mux_c = lvl[0];
  end

  if (REG_OUT_EN != 0) begin : g_reg
    logic out_q, out_d;

    always_comb begin
      out_d = mux_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_q <= 1'b1;
      end else begin
        out_q <= out_d;
      end
    end

    assign bus.out = act_q[CFG_W-1] ? out_q : mux_c;
  end else begin : g_comb
    assign bus.out = mux_c;
  end
endmodule

// File: tb/tb_mux_tree_cfg_chain.sv
// Scoreboarded random/directed bench for mux_tree_cfg_chain against a
// behavioural model of chain, active register and routing selection.
module tb_mux_tree_cfg_chain;
  localparam int unsigned N_IN  = 15;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CFG_W = 5;

  typedef struct {
    logic             out;
    logic             tail;
    logic             valid;
    logic [CFG_W-1:0] sram;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  exp_t exp_q[$];

  // Reference model state
  bit   sr_m[$];
  bit   act_m[CFG_W];
  bit   valid_m;
  bit   outq_m;

  mux_tree_cfg_chain_if #(.N_IN(N_IN), .CFG_W(CFG_W)) bus ();

  mux_tree_cfg_chain #(.N_IN(N_IN), .SEL_W(SEL_W), .REG_OUT_EN(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    sr_m.delete();
    for (int i = 0; i < int'(CFG_W); i++) sr_m.push_back(1'b0);
    for (int i = 0; i < int'(CFG_W); i++) act_m[i] = 1'b0;
    valid_m = 1'b0;
    outq_m  = 1'b1;
  endfunction

  function automatic logic [CFG_W-1:0] act_bits();
    logic [CFG_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(CFG_W); i++) v[i] = act_m[i];
    return v;
  endfunction

  // Selected slot is (2^SEL_W - 1) minus the stored select value.
  function automatic logic model_mux(input logic [0:N_IN-1] d);
    int s;
    int idx;
    s = 0;
    for (int k = 0; k < int'(SEL_W); k++) s += int'(act_m[k]) << k;
    idx = (1 << SEL_W) - 1 - s;
    if (idx < int'(N_IN)) return d[idx];
    return 1'b1;
  endfunction

  task automatic step(input bit en, input bit head, input bit commit,
                      input logic [0:N_IN-1] din, input bit rstn);
    exp_t e;
    logic m;
    reset_n        = rstn;
    bus.cfg_en     = en;
    bus.ccff_head  = head;
    bus.cfg_commit = commit;
    bus.in         = din;
    if (!rstn) model_reset();
    m       = model_mux(din);
    e.out   = act_m[SEL_W] ? outq_m : m;
    e.tail  = sr_m[CFG_W-1];
    e.valid = valid_m;
    e.sram  = act_bits();
    exp_q.push_back(e);
    @(posedge clk);
    if (rstn) begin
      outq_m = m;
      if (commit) begin
        for (int k = 0; k < int'(CFG_W); k++) act_m[k] = sr_m[k];
        valid_m = 1'b1;
      end
      if (en) begin
        sr_m.push_front(head);
        void'(sr_m.pop_back());
      end
    end
    #1;
  endtask

  function automatic logic [0:N_IN-1] rnd_in();
    return N_IN'($urandom);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rnd_in(), 1'b1);
  endtask

  // Stream MSB first so the literal equals the resulting sram_q.
  task automatic load(input logic [CFG_W-1:0] stream, input bit do_commit);
    for (int i = int'(CFG_W) - 1; i >= 0; i--) step(1'b1, stream[i], 1'b0, rnd_in(), 1'b1);
    if (do_commit) step(1'b0, 1'b0, 1'b1, rnd_in(), 1'b1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out",       32'(bus.out),       32'(e.out));
      chk("ccff_tail", 32'(bus.ccff_tail), 32'(e.tail));
      chk("cfg_valid", 32'(bus.cfg_valid), 32'(e.valid));
      chk("sram_q",    32'(bus.sram_q),    32'(e.sram));
    end
  end

  initial begin
    total          = 0;
    bad            = 0;
    clk            = 1'b0;
    reset_n        = 1'b0;
    bus.cfg_en     = 1'b0;
    bus.ccff_head  = 1'b0;
    bus.cfg_commit = 1'b0;
    bus.in         = '0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, rnd_in(), 1'b0);
    step(1'b0, 1'b0, 1'b0, rnd_in(), 1'b0);

    // Combinational select of in[0], then in[9]
    load(5'b01111, 1'b1);
    idle(8);
    load(5'b00110, 1'b1);
    idle(8);

    // Constant slot
    load(5'b00000, 1'b1);
    idle(6);

    // Registered mode, index 3
    load(5'b11100, 1'b1);
    idle(8);

    // Shift without commit, then simultaneous shift and commit
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0, rnd_in(), 1'b1);
    idle(2);
    step(1'b1, 1'($urandom), 1'b1, rnd_in(), 1'b1);
    idle(3);
    step(1'b0, 1'b0, 1'b1, rnd_in(), 1'b1);
    idle(2);

    // Reset mid-run, then mid-stream
    step(1'b1, 1'b1, 1'b1, rnd_in(), 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, rnd_in(), 1'b1);
    step(1'b1, 1'b1, 1'b0, rnd_in(), 1'b0);
    load(5'b00110, 1'b1);
    idle(6);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
           rnd_in(), ($urandom_range(0, 63) != 0));
    end
    idle(4);

    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_tree_cfg_chain.md
# mux_tree_cfg_chain

Parametrised routing multiplexer with its own configuration storage, for the connection-block and switch-block routing tracks. It selects one of `N_IN` inputs through a binary select tree, with unused slots tied to constant 1. Its configuration bits live in a local shift chain (`ccff_head` to `ccff_tail`) with a separate shadow (active) register, so shifting never disturbs the routed signal until an explicit commit. An optional mode bit retimes the output through a flop.

## Interface
Parameters:
- `N_IN`, 15, number of data inputs; 2 ≤ `N_IN` ≤ 2^`SEL_W`.
- `SEL_W`, 4, select bits (tree levels).
- `REG_OUT_EN`, 1, 1 = mode bit and output flop exist; 0 = combinational only.
- Derived: `CFG_W` = `SEL_W` + `REG_OUT_EN` (chain length).

Ports:
- `clk` in 1: single clock for chain, shadow and output flop; rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_en` in 1: shift the chain by one bit this cycle.
- `ccff_head` in 1: serial configuration input.
- `ccff_tail` out 1: serial output, equal to `sr[CFG_W-1]`.
- `cfg_commit` in 1: copy `sr` into the active register.
- `cfg_valid` out 1: 1 after the first commit following reset.
- `in` in `N_IN`: data inputs, indexed `[0:N_IN-1]`.
- `sram_q` out `CFG_W`: readback of the active register.
- `out` out 1: routed output.

## Operation
- **Chain `sr[0:CFG_W-1]`.**
  - When `cfg_en`=1: `sr[0]`←`ccff_head` and `sr[i]`←`sr[i-1]`.
  - Otherwise `sr` holds.
  - Stream order: mode bit first (if present), then `sram[SEL_W-1]`, …, `sram[0]` last.
  - After the stream, `sr[k]`=`sram[k]` for k<`SEL_W`, and `sr[SEL_W]`=mode.
- **Active register `act`.**
  - Loads `sr` on a `cfg_commit` edge.
  - If `cfg_en` and `cfg_commit` are both high in the same cycle, `act` takes the pre-shift `sr`.
- **Select decode.**
  - s = `act[SEL_W-1:0]`, with bit k = `sram[k]`.
  - index = bitwise NOT of s, over `SEL_W` bits. All ones selects `in[0]`; `sram[0]`=0 selects the odd member of each pair.
  - index ≥ `N_IN` gives constant 1.
- **Mode.** mode = `act[SEL_W]` when `REG_OUT_EN`=1, else 0.
  - mode 0: `out` = mux(index), purely combinational from `in` and `act`.
  - mode 1: `out` = `out_q`, where `out_q` ← mux(index) on every `clk` edge.
- **Glitch freedom.** Shifting `sr` never changes `out`; only a commit or an `in` change can.

## Timing
- **Reset** (async assert; release synchronised by the user):
  - `sr` = 0, `act` = 0, `cfg_valid` = 0, `ccff_tail` = 0.
  - `out_q` = 1, and `sram_q` = 0.
  - `out` = `in[2^SEL_W-1]` if that input exists, else 1.
- **Chain latency.** A bit presented on `ccff_head` appears on `ccff_tail` after `CFG_W` enabled edges. Disabled cycles do not count toward this.
- **Commit.** At edge t, `act`, `sram_q` and `cfg_valid` update at t.
  - In mode 0, `out` reflects the new select in the same cycle after t.
  - In mode 1, `out` holds the value captured at t under the old select, and shows the new selection from t+1.
- **Registered path.** An `in` change before edge t appears on `out` at t (one cycle of latency). The combinational path has zero cycles of latency.
- **Repeated commits** with unchanged `sr` are idempotent.
- **Reset mid-shift or mid-commit.** Everything returns to reset values immediately, and the partial stream is discarded.

## Test plan
Defaults apply (`N_IN`=15, `SEL_W`=4, `CFG_W`=5).
1. **Reset.** Assert `reset_n`=0 mid-run.
   - Required: `out`=1, `ccff_tail`=0, `cfg_valid`=0, `sram_q`=5'b00000, all immediately and asynchronously.
2. **Combinational select.** Shift the stream 0,1,1,1,1, then commit.
   - Required: `sram_q`=5'b01111 and `cfg_valid`=1.
   - Toggle `in[0]`: `out` follows it with no clock edge; toggling `in[1..14]` has no effect.
   - Then shift 0,0,1,1,0 (`sram`=4'b0110, s=6) and commit: `out` follows `in[9]`.
3. **Constant slot.** Commit all zeros (index 15).
   - Required: `out`=1 regardless of `in`.
4. **Registered mode.** Shift 1,1,1,0,0 (mode=1, s=12, index 3) and commit.
   - Toggle `in[3]` between edges t-1 and t: `out` changes exactly at edge t and holds until the next edge.
5. **Shift without commit; simultaneous events.**
   - Shift 7 random bits with `cfg_commit`=0: `out` never changes, and `ccff_tail` emits the prior chain contents delayed by 5 enabled edges.
   - Assert `cfg_en` and `cfg_commit` together: `act` equals the pre-shift `sr`.
6. **Reset mid-stream.** Pulse `reset_n` low after 3 of 5 shifts.
   - Required: chain cleared, `act`=0, and the following full 5-bit stream plus commit selects correctly.
